// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH stream demultiplexer with unicast/broadcast routing.
// Latency: one cycle, accept at edge n -> y / y_valid visible after edge n; 1 word/cycle sustained.
// Backpressure: i_ready drops while any pending channel withholds y_ready; per-channel bits clear independently.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   i, sel, bcast    input word, destination index, broadcast request
//   i_valid/i_ready  input handshake (i_ready is combinational from y_ready)
//   y                held word, shared by all channels
//   y_valid/y_ready  per-channel output handshake, bit k = channel k
//   err              one-cycle pulse: word accepted with sel >= NCH and bcast = 0
//   cnt              (only with DEMUX_STREAM_CNT_EN) NCH saturating 16-bit transfer
//                    counters, channel k in bits [16k+15:16k]
//
// Parameters: DW data width, NCH channel count (>= 2), SW select width (NCH <= 2**SW).
// Optional feature macro: DEMUX_STREAM_CNT_EN.
module demux_stream #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     i,
  input  logic [SW-1:0]     sel,
  input  logic              bcast,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [DW-1:0]     y,
  output logic [NCH-1:0]    y_valid,
  input  logic [NCH-1:0]    y_ready,
  output logic              err
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [NCH*16-1:0] cnt
`endif
);

  // Channel count widened by one bit so sel can be compared without truncation.
  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  logic [DW-1:0]  hold_q, hold_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic           err_q, err_d;

  logic           accept;
  logic           sel_ok;
  logic [NCH-1:0] onehot;
  logic [NCH-1:0] xfer;

  // A new word may enter once nothing would remain pending after this cycle.
  assign i_ready = ((pend_q & ~y_ready) == '0);
  assign accept  = i_valid && i_ready;
  assign xfer    = pend_q & y_ready;

  assign sel_ok  = ({1'b0, sel} < NCH_W);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NCH; k++) begin
      onehot[k] = ({1'b0, sel} == (SW+1)'(k));
    end
  end

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q & ~y_ready;
    err_d  = 1'b0;
    if (accept) begin
      // The new word's mask replaces whatever was completing this cycle.
      // An out-of-range word is still captured but never made visible.
      hold_d = i;
      if (bcast) begin
        pend_d = '1;
      end else if (sel_ok) begin
        pend_d = onehot;
      end else begin
        pend_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign y       = hold_q;
  assign y_valid = pend_q;
  assign err     = err_q;

`ifdef DEMUX_STREAM_CNT_EN
  logic [NCH-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NCH; k++) begin
      // Saturate rather than wrap so a long-running channel never reads low.
      if (xfer[k] && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  // Transfer strobes only feed the optional counters.
  logic unused_xfer;
  assign unused_xfer = ^xfer;
`endif

endmodule
